gcd_req_client: RTL and testbench
=================================

Name: gcd_req_client

Overview:
- Request-side counterpart to the 16-bit GCD unit: drives its 32-bit request stream {a,b} and consumes its 16-bit response stream.
- Accepts one command describing a batch of N operand pairs, issues them as val/rdy requests, and collects N responses.
- Returns a summary result (wrapping sum of GCDs, count of coprime pairs) on a result stream.
- Sits between a host/test controller and one GCD unit, or any latency-insensitive unit with the same message formats.

Parameters:
- p_max_outstanding, 2, max requests issued but not yet answered; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- cmd_val  input  1  command valid.
- cmd_rdy  output  1  command ready.
- cmd_msg  input  40  [39:32] N (pair count), [31:16] a0, [15:0] b0.
- req_val  output  1  request valid to GCD unit.
- req_rdy  input  1  request ready from GCD unit.
- req_msg  output  32  [31:16] a operand, [15:0] b operand.
- resp_val  input  1  response valid from GCD unit.
- resp_rdy  output  1  response ready to GCD unit.
- resp_msg  input  16  GCD result.
- result_val  output  1  batch summary valid.
- result_rdy  input  1  batch summary ready.
- result_msg  output  24  [23:16] count of responses equal to 1, [15:0] wrapping sum of responses.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Handshakes: a transfer ("fire") occurs on a posedge where val && rdy. Once asserted, val and msg stay stable until the fire. rdy may depend combinationally on state only, never on the partner's val.
- Reset (async assert):
  - state=IDLE; issued, received, outstanding, sum and ones all = 0.
  - Outputs: cmd_rdy=1, req_val=0, resp_rdy=0, result_val=0, req_msg=0, result_msg=0.
  - Reset mid-batch abandons the batch with no result. The GCD unit shares reset, so no stale response survives.
- States:
  - IDLE:
    - cmd_rdy=1, all other val/rdy outputs 0.
    - On cmd fire: latch N, a0, b0; clear counters and accumulators.
    - Next state is RUN if N!=0, otherwise DONE.
  - RUN:
    - req_val = (issued<N) && (outstanding<p_max_outstanding).
    - req_msg = {a0+issued (mod 2^16), b0}.
    - resp_rdy=1 and cmd_rdy=0.
    - req fire: issued++. resp fire: received++, sum += resp_msg (mod 2^16), ones++ if resp_msg==16'd1 (mod 2^8).
    - outstanding: +1 on req fire only, −1 on resp fire only, unchanged when both fire in the same cycle.
    - Go to DONE on the cycle the resp fire makes received==N.
  - DONE:
    - result_val=1, result_msg={ones,sum}; all other val/rdy 0.
    - On result fire go to IDLE. Accumulators are cleared on the next cmd fire.
- Latency:
  - cmd fire at cycle t → req_val first high at t+1, subject to the outstanding limit.
  - Last resp fire at t → result_val at t+1.
  - N=0: cmd fire at t → result_val at t+1 with result_msg=0.
- Ordering: responses are assumed in-order and are counted only; a response arriving when received==N is impossible by construction (resp_rdy=0 outside RUN).
- Throughput: with p_max_outstanding≥2 and a responder accepting every cycle, back-to-back request fires occur with no bubble.
- Widths: counters issued and received are 8 bits; outstanding is 4 bits. Operand a wraps at 16 bits, so a0=0xFFFF then 0x0000.

Test Plan:
- N=1, a0=15, b0=5, GCD unit attached → one req 0x000F_0005; resp 5; result_msg=0x00_0005 one cycle after resp fire.
- N=4, a0=6, b0=4 → reqs a=6,7,8,9 with b=4; resps 2,1,4,1; result_msg=0x02_0008.
- N=0 → no req_val ever; result_val at cycle t+1 with 0x000000; cmd_rdy low until result fire.
- Fake responder: req_rdy=1, resp_val=0 for 10 cycles, p_max_outstanding=2, N=5 → exactly 2 req fires, then req_val=0. Release resp (value 3 each) → all 5 issued; result_msg=0x00_000F.
- Fake responder: a0=0xFFFF, b0=0, N=2 → req_msg 0xFFFF_0000 then 0x0000_0000 (a wraps). Same-cycle req+resp fire holds outstanding steady.
- Reset asserted mid-RUN after 2 of 4 responses → outputs return to reset values immediately (async). A new cmd N=1, a0=9, b0=3 → result_msg=0x00_0003 (no carry-over).

Source files
------------

// File: rtl/gcd_req_client.sv
// gcd_req_client: batch request generator for a 16-bit GCD unit.
// Takes one command {N, a0, b0}. Issues N requests {a0+i, b0} while keeping
// at most p_max_outstanding of them unanswered. Collects the N responses and
// then offers {count of responses equal to 1, wrapping sum of responses}.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a batch command (cmd_rdy high)
// RUN   | issuing requests and collecting responses
// DONE  | holding the batch summary on result_msg until it is taken
module gcd_req_client #(
   parameter int p_max_outstanding = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_val,
   output logic        cmd_rdy,
   input  logic [39:0] cmd_msg,
   output logic        req_val,
   input  logic        req_rdy,
   output logic [31:0] req_msg,
   input  logic        resp_val,
   output logic        resp_rdy,
   input  logic [15:0] resp_msg,
   output logic        result_val,
   input  logic        result_rdy,
   output logic [23:0] result_msg
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [3:0] c_max_outstanding = 4'(p_max_outstanding);

   state_t      state, state_n;
   logic [7:0]  n_pairs, n_pairs_n;
   logic [15:0] a0, a0_n;
   logic [15:0] b0, b0_n;
   logic [7:0]  issued, issued_n;
   logic [7:0]  received, received_n;
   logic [3:0]  outstanding, outstanding_n;
   logic [15:0] sum, sum_n;
   logic [7:0]  ones, ones_n;

   logic cmd_fire, req_fire, resp_fire, result_fire;

   // The val/rdy outputs are registers, so every fire is a function of flops
   // plus the partner's signal; rdy never looks at the partner's val.
   assign cmd_fire    = cmd_val    && cmd_rdy;
   assign req_fire    = req_val    && req_rdy;
   assign resp_fire   = resp_val   && resp_rdy;
   assign result_fire = result_val && result_rdy;

   // Next-state and next-datapath values for the batch sequencer.
   always_comb begin
      state_n       = state;
      n_pairs_n     = n_pairs;
      a0_n          = a0;
      b0_n          = b0;
      issued_n      = issued;
      received_n    = received;
      outstanding_n = outstanding;
      sum_n         = sum;
      ones_n        = ones;
      case (state)
         IDLE: begin
            if (cmd_fire) begin
               n_pairs_n     = cmd_msg[39:32];
               a0_n          = cmd_msg[31:16];
               b0_n          = cmd_msg[15:0];
               issued_n      = 8'd0;
               received_n    = 8'd0;
               outstanding_n = 4'd0;
               sum_n         = 16'd0;
               ones_n        = 8'd0;
               state_n       = (cmd_msg[39:32] != 8'd0) ? RUN : DONE;
            end
         end
         RUN: begin
            if (req_fire) begin
               issued_n = issued + 8'd1;
            end
            if (resp_fire) begin
               received_n = received + 8'd1;
               sum_n      = sum + resp_msg;
               if (resp_msg == 16'd1) begin
                  ones_n = ones + 8'd1;
               end
            end
            // A request and a response in the same cycle cancel out.
            case ({req_fire, resp_fire})
               2'b10:   outstanding_n = outstanding + 4'd1;
               2'b01:   outstanding_n = outstanding - 4'd1;
               default: outstanding_n = outstanding;
            endcase
            if (resp_fire && (received_n == n_pairs)) begin
               state_n = DONE;
            end
         end
         DONE: begin
            if (result_fire) begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // State, counters and registered handshake outputs derived from next state,
   // so req_val can stay high across consecutive request fires.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         n_pairs     <= 8'd0;
         a0          <= 16'd0;
         b0          <= 16'd0;
         issued      <= 8'd0;
         received    <= 8'd0;
         outstanding <= 4'd0;
         sum         <= 16'd0;
         ones        <= 8'd0;
         cmd_rdy     <= 1'b1;
         req_val     <= 1'b0;
         req_msg     <= 32'd0;
         resp_rdy    <= 1'b0;
         result_val  <= 1'b0;
         result_msg  <= 24'd0;
      end else begin
         state       <= state_n;
         n_pairs     <= n_pairs_n;
         a0          <= a0_n;
         b0          <= b0_n;
         issued      <= issued_n;
         received    <= received_n;
         outstanding <= outstanding_n;
         sum         <= sum_n;
         ones        <= ones_n;
         cmd_rdy     <= (state_n == IDLE);
         req_val     <= (state_n == RUN) && (issued_n < n_pairs_n) &&
                        (outstanding_n < c_max_outstanding);
         req_msg     <= (state_n == RUN) ? {a0_n + {8'd0, issued_n}, b0_n} : 32'd0;
         resp_rdy    <= (state_n == RUN);
         result_val  <= (state_n == DONE);
         result_msg  <= (state_n == DONE) ? {ones_n, sum_n} : 24'd0;
      end
   end

endmodule

// File: tb/tb_gcd_req_client.sv
// Directed bench for gcd_req_client with a behavioural GCD responder.
module tb_gcd_req_client;

   logic        clk;
   logic        reset;
   logic        cmd_val;
   logic        cmd_rdy;
   logic [39:0] cmd_msg;
   logic        req_val;
   logic        req_rdy;
   logic [31:0] req_msg;
   logic        resp_val;
   logic        resp_rdy;
   logic [15:0] resp_msg;
   logic        result_val;
   logic        result_rdy;
   logic [23:0] result_msg;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // responder control and observation
   logic        req_rdy_en  = 1'b1;
   logic        resp_en     = 1'b1;
   logic        resp_const  = 1'b0;
   logic [15:0] const_val   = 16'd0;
   logic [15:0] rq[$];
   logic [31:0] req_log[$];
   logic        pr = 1'b0;
   logic        ps = 1'b0;
   logic [31:0] req_msg_seen = 32'd0;
   int          resp_cnt = 0;
   int          last_resp_cyc = 0;
   int          tb_outst = 0;
   logic        both_seen = 1'b0;
   logic [3:0]  outst_at_both = 4'd0;

   gcd_req_client #(.p_max_outstanding(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .cmd_val    (cmd_val),
      .cmd_rdy    (cmd_rdy),
      .cmd_msg    (cmd_msg),
      .req_val    (req_val),
      .req_rdy    (req_rdy),
      .req_msg    (req_msg),
      .resp_val   (resp_val),
      .resp_rdy   (resp_rdy),
      .resp_msg   (resp_msg),
      .result_val (result_val),
      .result_rdy (result_rdy),
      .result_msg (result_msg)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   function automatic logic [15:0] gcd16(input logic [15:0] a_in, input logic [15:0] b_in);
      logic [15:0] a, b, t;
      a = a_in;
      b = b_in;
      while (b != 16'd0) begin
         t = a % b;
         a = b;
         b = t;
      end
      return a;
   endfunction

   // In-order responder: fires predicted at one falling edge are committed at
   // the next, since the DUT outputs only move on the rising edge between.
   initial begin
      req_rdy  = 1'b0;
      resp_val = 1'b0;
      resp_msg = 16'd0;
      forever begin
         @(negedge clk);
         if (reset) begin
            rq.delete();
            tb_outst = 0;
         end else begin
            if (pr) begin
               req_log.push_back(req_msg_seen);
               rq.push_back(resp_const ? const_val : gcd16(req_msg_seen[31:16], req_msg_seen[15:0]));
               tb_outst++;
            end
            if (ps) begin
               void'(rq.pop_front());
               resp_cnt++;
               last_resp_cyc = cyc;
               tb_outst--;
            end
            if (pr && ps) begin
               both_seen     = 1'b1;
               outst_at_both = dut.outstanding;
            end
         end
         resp_val     = resp_en && (rq.size() > 0);
         resp_msg     = (rq.size() > 0) ? rq[0] : 16'd0;
         req_rdy      = req_rdy_en;
         pr           = !reset && req_val && req_rdy;
         ps           = !reset && resp_val && resp_rdy;
         req_msg_seen = req_msg;
      end
   end

   task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present a command and return on the falling edge just after it fired.
   task automatic send_cmd(input logic [7:0] n, input logic [15:0] a, input logic [15:0] b);
      int k;
      k = 0;
      @(negedge clk);
      cmd_val = 1'b1;
      cmd_msg = {n, a, b};
      while (!cmd_rdy && k < 200) begin
         @(negedge clk);
         k++;
      end
      if (k >= 200) chk("cmd_timeout", 40'(k), 40'd0);
      @(negedge clk);
      cmd_val = 1'b0;
      cmd_msg = 40'd0;
   endtask

   // Wait for the summary, check it and its latency, then accept it.
   task automatic take_result(input string tag, input logic [23:0] exp, input logic chk_lat);
      int k;
      k = 0;
      while (!result_val && k < 500) begin
         @(negedge clk);
         k++;
      end
      if (k >= 500) chk({tag, "_timeout"}, 40'(k), 40'd0);
      chk({tag, "_msg"}, 40'(result_msg), 40'(exp));
      if (chk_lat) chk({tag, "_lat"}, 40'(cyc), 40'(last_resp_cyc));
      result_rdy = 1'b1;
      @(negedge clk);
      result_rdy = 1'b0;
   endtask

   initial begin
      reset      = 1'b1;
      cmd_val    = 1'b0;
      cmd_msg    = 40'd0;
      result_rdy = 1'b0;
      repeat (3) @(negedge clk);

      // reset values
      chk("rst_cmd_rdy", 40'(cmd_rdy), 40'd1);
      chk("rst_req_val", 40'(req_val), 40'd0);
      chk("rst_resp_rdy", 40'(resp_rdy), 40'd0);
      chk("rst_result_val", 40'(result_val), 40'd0);
      chk("rst_req_msg", 40'(req_msg), 40'd0);
      chk("rst_result_msg", 40'(result_msg), 40'd0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // N=1, 15/5
      req_log.delete();
      send_cmd(8'd1, 16'd15, 16'd5);
      chk("t1_req_val", 40'(req_val), 40'd1);
      chk("t1_req_msg", 40'(req_msg), 40'h000F0005);
      take_result("t1", 24'h000005, 1'b1);
      chk("t1_nreq", 40'(req_log.size()), 40'd1);

      // N=4, a=6..9, b=4 -> gcds 2,1,4,1
      req_log.delete();
      send_cmd(8'd4, 16'd6, 16'd4);
      take_result("t2", 24'h020008, 1'b1);
      chk("t2_nreq", 40'(req_log.size()), 40'd4);
      chk("t2_req0", 40'(req_log[0]), 40'h00060004);
      chk("t2_req3", 40'(req_log[3]), 40'h00090004);

      // N=0 goes straight to DONE
      req_log.delete();
      send_cmd(8'd0, 16'd7, 16'd7);
      chk("t3_result_val", 40'(result_val), 40'd1);
      chk("t3_req_val", 40'(req_val), 40'd0);
      chk("t3_cmd_rdy", 40'(cmd_rdy), 40'd0);
      take_result("t3", 24'h000000, 1'b0);
      chk("t3_nreq", 40'(req_log.size()), 40'd0);
      chk("t3_cmd_rdy_after", 40'(cmd_rdy), 40'd1);

      // outstanding limit with a stalled responder
      req_log.delete();
      resp_en    = 1'b0;
      resp_const = 1'b1;
      const_val  = 16'd3;
      send_cmd(8'd5, 16'd1, 16'd1);
      repeat (10) @(negedge clk);
      chk("t4_nreq_stalled", 40'(req_log.size()), 40'd2);
      chk("t4_req_val_stalled", 40'(req_val), 40'd0);
      resp_en = 1'b1;
      take_result("t4", 24'h00000F, 1'b1);
      chk("t4_nreq", 40'(req_log.size()), 40'd5);

      // operand a wraps; same-cycle req+resp fire keeps outstanding
      req_log.delete();
      resp_const = 1'b0;
      both_seen  = 1'b0;
      send_cmd(8'd2, 16'hFFFF, 16'h0000);
      take_result("t5", 24'h00FFFF, 1'b1);
      chk("t5_req0", 40'(req_log[0]), 40'hFFFF0000);
      chk("t5_req1", 40'(req_log[1]), 40'h00000000);
      chk("t5_both_seen", 40'(both_seen), 40'd1);
      chk("t5_outst_both", 40'(outst_at_both), 40'd1);

      // reset mid-batch, then a clean batch
      resp_cnt = 0;
      send_cmd(8'd4, 16'd6, 16'd4);
      begin
         int k;
         k = 0;
         while (resp_cnt < 2 && k < 200) begin
            @(negedge clk);
            k++;
         end
         chk("t6_two_resps", 40'(resp_cnt), 40'd2);
      end
      reset = 1'b1;
      #1;
      chk("t6_cmd_rdy", 40'(cmd_rdy), 40'd1);
      chk("t6_req_val", 40'(req_val), 40'd0);
      chk("t6_resp_rdy", 40'(resp_rdy), 40'd0);
      chk("t6_result_val", 40'(result_val), 40'd0);
      chk("t6_result_msg", 40'(result_msg), 40'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      send_cmd(8'd1, 16'd9, 16'd3);
      take_result("t6", 24'h000003, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
